// File: rtl/card_ram_if.sv
// Request/acknowledge port between the card RAM responder and the RAM arbiter.
interface card_ram_if #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 8
);
  logic              mem_req;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req, mem_wr, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_wr, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/card_ram_port.sv
// Language-card RAM responder: one req/ack transaction per qualified bus strobe.
// Optional CARD_RAM_TIMEOUT_EN aborts a request that sees no mem_ack (adds tmo_err).
module card_ram_port #(
  parameter int ADDR_W     = 18,
  parameter int DATA_W     = 8,
  parameter int TMO_CYCLES = 24
) (
  input  logic              mclk28,
  input  logic              reset_in,
  input  logic              bus_stb,
  input  logic              we,
  input  logic [ADDR_W-1:0] ram_addr,
  input  logic              card_ram_rd,
  input  logic              card_ram_we,
  input  logic [DATA_W-1:0] cpu_dout,
  card_ram_if.master        mem,
  output logic [DATA_W-1:0] card_dout,
  output logic              card_oe,
  output logic              busy,
  output logic              overrun
`ifdef CARD_RAM_TIMEOUT_EN
  ,
  output logic              tmo_err
`endif
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t            state_reg, state_next;
  logic              req_reg, req_next;
  logic              wr_reg, wr_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [DATA_W-1:0] wdata_reg, wdata_next;
  logic [DATA_W-1:0] dout_reg, dout_next;
  logic              oe_reg, oe_next;
  logic              ovr_reg, ovr_next;
  logic              wr_q, rd_q;

`ifdef CARD_RAM_TIMEOUT_EN
  localparam int TMO_W = $clog2(TMO_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt_reg, tmo_cnt_next;
  logic             tmo_err_reg, tmo_err_next;
`endif

  assign wr_q = we & card_ram_we;
  assign rd_q = ~we & card_ram_rd;

  always_ff @(posedge mclk28) begin
    if (reset_in) begin
      state_reg <= IDLE;
      req_reg   <= 1'b0;
      wr_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      dout_reg  <= '0;
      oe_reg    <= 1'b0;
      ovr_reg   <= 1'b0;
`ifdef CARD_RAM_TIMEOUT_EN
      tmo_cnt_reg <= '0;
      tmo_err_reg <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      req_reg   <= req_next;
      wr_reg    <= wr_next;
      addr_reg  <= addr_next;
      wdata_reg <= wdata_next;
      dout_reg  <= dout_next;
      oe_reg    <= oe_next;
      ovr_reg   <= ovr_next;
`ifdef CARD_RAM_TIMEOUT_EN
      tmo_cnt_reg <= tmo_cnt_next;
      tmo_err_reg <= tmo_err_next;
`endif
    end
  end

  always_comb begin
    state_next = state_reg;
    req_next   = req_reg;
    wr_next    = wr_reg;
    addr_next  = addr_reg;
    wdata_next = wdata_reg;
    dout_next  = dout_reg;
    oe_next    = oe_reg;
    ovr_next   = ovr_reg;
`ifdef CARD_RAM_TIMEOUT_EN
    tmo_cnt_next = tmo_cnt_reg;
    tmo_err_next = tmo_err_reg;
`endif

    case (state_reg)
      IDLE: begin
        if (bus_stb) begin
          oe_next = 1'b0;
          if (wr_q || rd_q) begin
            addr_next  = ram_addr;
            wdata_next = cpu_dout;
            wr_next    = wr_q;
            req_next   = 1'b1;
            state_next = REQ;
`ifdef CARD_RAM_TIMEOUT_EN
            tmo_cnt_next = '0;
`endif
          end
        end
      end
      REQ: begin
        if (mem.mem_ack) begin
          req_next   = 1'b0;
          state_next = DONE;
          if (!wr_reg) begin
            dout_next = mem.mem_rdata;
            oe_next   = 1'b1;
          end
`ifdef CARD_RAM_TIMEOUT_EN
        end else if (tmo_cnt_reg == TMO_W'(TMO_CYCLES - 1)) begin
          // Abort: a read returns all-ones so the CPU sees a floating-bus value.
          req_next     = 1'b0;
          state_next   = DONE;
          tmo_err_next = 1'b1;
          if (!wr_reg) begin
            dout_next = {DATA_W{1'b1}};
            oe_next   = 1'b1;
          end
        end else begin
          tmo_cnt_next = tmo_cnt_reg + 1'b1;
`endif
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        req_next   = 1'b0;
      end
    endcase

    // DONE still counts as busy, so a strobe there is an overrun too.
    if (bus_stb && (state_reg != IDLE)) begin
      ovr_next = 1'b1;
    end
  end

  assign mem.mem_req   = req_reg;
  assign mem.mem_wr    = wr_reg;
  assign mem.mem_addr  = addr_reg;
  assign mem.mem_wdata = wdata_reg;
  assign card_dout     = dout_reg;
  assign card_oe       = oe_reg;
  assign busy          = (state_reg != IDLE);
  assign overrun       = ovr_reg;
`ifdef CARD_RAM_TIMEOUT_EN
  assign tmo_err       = tmo_err_reg;
`endif

endmodule

// File: tb/tb_card_ram_port.sv
// Scoreboard bench for card_ram_port: expected requests/read data queued at stimulus time.
module tb_card_ram_port;
  localparam int ADDR_W = 18;
  localparam int DATA_W = 8;

  logic              mclk28 = 1'b0;
  logic              reset_in = 1'b1;
  logic              bus_stb = 1'b0;
  logic              we = 1'b0;
  logic [ADDR_W-1:0] ram_addr = '0;
  logic              card_ram_rd = 1'b0;
  logic              card_ram_we = 1'b0;
  logic [DATA_W-1:0] cpu_dout = '0;
  logic [DATA_W-1:0] card_dout;
  logic              card_oe;
  logic              busy;
  logic              overrun;
`ifdef CARD_RAM_TIMEOUT_EN
  logic              tmo_err;
`endif

  card_ram_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mif ();

  card_ram_port #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TMO_CYCLES(24)) dut (
    .mclk28      (mclk28),
    .reset_in    (reset_in),
    .bus_stb     (bus_stb),
    .we          (we),
    .ram_addr    (ram_addr),
    .card_ram_rd (card_ram_rd),
    .card_ram_we (card_ram_we),
    .cpu_dout    (cpu_dout),
    .mem         (mif),
    .card_dout   (card_dout),
    .card_oe     (card_oe),
    .busy        (busy),
    .overrun     (overrun)
`ifdef CARD_RAM_TIMEOUT_EN
    ,
    .tmo_err     (tmo_err)
`endif
  );

  always #5 mclk28 = ~mclk28;

  int chk_cnt = 0;
  int pass_cnt = 0;

  // {wr, addr, wdata} of each request the DUT should raise, and read data it should return
  logic [ADDR_W+DATA_W:0] req_q[$];
  logic [DATA_W-1:0]      rd_q[$];
  logic [ADDR_W+DATA_W:0] exp_req;
  logic [DATA_W-1:0]      exp_rd;

  task automatic tick();
    @(posedge mclk28);
    #1;
  endtask

  task automatic strobe(input logic w, input logic r_en, input logic w_en,
                        input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    bus_stb     = 1'b1;
    we          = w;
    card_ram_rd = r_en;
    card_ram_we = w_en;
    ram_addr    = a;
    cpu_dout    = d;
    tick();
    bus_stb = 1'b0;
  endtask

  task automatic test_reset();
    reset_in = 1'b1;
    tick();
    tick();
    chk_cnt++;
    if ({mif.mem_req, mif.mem_wr, mif.mem_addr, mif.mem_wdata, card_dout, card_oe, busy, overrun} !== '0)
      $display("FAIL reset_vals: got req=%b wr=%b addr=%h wdata=%h dout=%h oe=%b busy=%b ovr=%b, want all 0",
               mif.mem_req, mif.mem_wr, mif.mem_addr, mif.mem_wdata, card_dout, card_oe, busy, overrun);
    else pass_cnt++;
`ifdef CARD_RAM_TIMEOUT_EN
    chk_cnt++;
    if (tmo_err !== 1'b0) $display("FAIL reset_tmo_err: got %b want 0", tmo_err);
    else pass_cnt++;
`endif
    reset_in = 1'b0;
    tick();
  endtask

  task automatic test_read_hit();
    req_q.push_back({1'b0, 18'h2_1234, 8'h00});
    strobe(1'b0, 1'b1, 1'b0, 18'h2_1234, 8'h00);
    chk_cnt++;
    if ({mif.mem_req, busy} !== 2'b11) $display("FAIL rd_req_rise: got req=%b busy=%b want 1 1", mif.mem_req, busy);
    else pass_cnt++;
    exp_req = req_q.pop_front();
    chk_cnt++;
    if ({mif.mem_wr, mif.mem_addr, mif.mem_wdata} !== exp_req)
      $display("FAIL rd_req_fields: got %h want %h", {mif.mem_wr, mif.mem_addr, mif.mem_wdata}, exp_req);
    else pass_cnt++;
    tick();
    tick();
    chk_cnt++;
    if ({mif.mem_req, mif.mem_addr, card_oe} !== {1'b1, 18'h2_1234, 1'b0})
      $display("FAIL rd_req_hold: got req=%b addr=%h oe=%b want 1 21234 0", mif.mem_req, mif.mem_addr, card_oe);
    else pass_cnt++;
    mif.mem_rdata = 8'h5A;
    mif.mem_ack   = 1'b1;
    rd_q.push_back(8'h5A);
    tick();
    mif.mem_ack = 1'b0;
    exp_rd = rd_q.pop_front();
    chk_cnt++;
    if ({mif.mem_req, card_oe, card_dout} !== {1'b0, 1'b1, exp_rd})
      $display("FAIL rd_data: got req=%b oe=%b dout=%h want 0 1 %h", mif.mem_req, card_oe, card_dout, exp_rd);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if (busy !== 1'b0) $display("FAIL rd_done_busy: got %b want 0", busy);
    else pass_cnt++;
    repeat (3) tick();
    chk_cnt++;
    if ({card_oe, card_dout} !== {1'b1, 8'h5A})
      $display("FAIL rd_data_held: got oe=%b dout=%h want 1 5a", card_oe, card_dout);
    else pass_cnt++;
  endtask

  task automatic test_write_protect();
    strobe(1'b1, 1'b0, 1'b0, 18'h3_FFFF, 8'h99);
    chk_cnt++;
    if ({mif.mem_req, busy, card_oe} !== 3'b000)
      $display("FAIL wp_write: got req=%b busy=%b oe=%b want 0 0 0", mif.mem_req, busy, card_oe);
    else pass_cnt++;
    chk_cnt++;
    if ({mif.mem_wr, mif.mem_addr, mif.mem_wdata} !== {1'b0, 18'h2_1234, 8'h00})
      $display("FAIL wp_no_latch: got %h want %h", {mif.mem_wr, mif.mem_addr, mif.mem_wdata}, {1'b0, 18'h2_1234, 8'h00});
    else pass_cnt++;
    tick();
    strobe(1'b0, 1'b0, 1'b1, 18'h0_0055, 8'h11);
    chk_cnt++;
    if ({mif.mem_req, busy, card_oe} !== 3'b000)
      $display("FAIL rom_read: got req=%b busy=%b oe=%b want 0 0 0", mif.mem_req, busy, card_oe);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_write();
    req_q.push_back({1'b1, 18'h0_D000, 8'hC3});
    strobe(1'b1, 1'b0, 1'b1, 18'h0_D000, 8'hC3);
    exp_req = req_q.pop_front();
    chk_cnt++;
    if ({mif.mem_req, mif.mem_wr, mif.mem_addr, mif.mem_wdata} !== {1'b1, exp_req})
      $display("FAIL wr_req: got req=%b fields=%h want 1 %h", mif.mem_req,
               {mif.mem_wr, mif.mem_addr, mif.mem_wdata}, exp_req);
    else pass_cnt++;
    // ack in the very cycle mem_req first rises
    mif.mem_ack = 1'b1;
    tick();
    mif.mem_ack = 1'b0;
    chk_cnt++;
    if ({mif.mem_req, card_oe, busy} !== 3'b001)
      $display("FAIL wr_fast_ack: got req=%b oe=%b busy=%b want 0 0 1", mif.mem_req, card_oe, busy);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if ({busy, card_oe} !== 2'b00) $display("FAIL wr_done: got busy=%b oe=%b want 0 0", busy, card_oe);
    else pass_cnt++;
  endtask

  task automatic test_overlap();
    req_q.push_back({1'b0, 18'h0_0100, 8'h00});
    strobe(1'b0, 1'b1, 1'b0, 18'h0_0100, 8'h00);
    exp_req = req_q.pop_front();
    chk_cnt++;
    if ({mif.mem_req, mif.mem_wr, mif.mem_addr, mif.mem_wdata} !== {1'b1, exp_req})
      $display("FAIL ovl_req: got req=%b fields=%h want 1 %h", mif.mem_req,
               {mif.mem_wr, mif.mem_addr, mif.mem_wdata}, exp_req);
    else pass_cnt++;
    strobe(1'b0, 1'b1, 1'b0, 18'h0_0001, 8'h00);
    chk_cnt++;
    if ({mif.mem_req, mif.mem_addr, overrun} !== {1'b1, 18'h0_0100, 1'b1})
      $display("FAIL ovl_ignored: got req=%b addr=%h ovr=%b want 1 00100 1", mif.mem_req, mif.mem_addr, overrun);
    else pass_cnt++;
    mif.mem_rdata = 8'h77;
    mif.mem_ack   = 1'b1;
    rd_q.push_back(8'h77);
    tick();
    mif.mem_ack = 1'b0;
    exp_rd = rd_q.pop_front();
    chk_cnt++;
    if ({card_oe, card_dout} !== {1'b1, exp_rd})
      $display("FAIL ovl_data: got oe=%b dout=%h want 1 %h", card_oe, card_dout, exp_rd);
    else pass_cnt++;
    tick();
    tick();
    chk_cnt++;
    if ({mif.mem_req, busy, overrun} !== 3'b001)
      $display("FAIL ovl_sticky: got req=%b busy=%b ovr=%b want 0 0 1", mif.mem_req, busy, overrun);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    req_q.push_back({1'b1, 18'h1_2345, 8'hA5});
    strobe(1'b1, 1'b0, 1'b1, 18'h1_2345, 8'hA5);
    exp_req = req_q.pop_front();
    chk_cnt++;
    if ({mif.mem_req, mif.mem_wr, mif.mem_addr, mif.mem_wdata} !== {1'b1, exp_req})
      $display("FAIL rst_mid_req: got req=%b fields=%h want 1 %h", mif.mem_req,
               {mif.mem_wr, mif.mem_addr, mif.mem_wdata}, exp_req);
    else pass_cnt++;
    reset_in = 1'b1;
    tick();
    reset_in = 1'b0;
    chk_cnt++;
    if ({mif.mem_req, busy, card_oe, overrun} !== 4'b0000)
      $display("FAIL rst_mid: got req=%b busy=%b oe=%b ovr=%b want 0 0 0 0", mif.mem_req, busy, card_oe, overrun);
    else pass_cnt++;
    mif.mem_rdata = 8'hEE;
    mif.mem_ack   = 1'b1;
    tick();
    mif.mem_ack = 1'b0;
    tick();
    chk_cnt++;
    if ({mif.mem_req, busy, card_oe, card_dout} !== {3'b000, 8'h00})
      $display("FAIL stale_ack: got req=%b busy=%b oe=%b dout=%h want 0 0 0 00", mif.mem_req, busy, card_oe, card_dout);
    else pass_cnt++;
  endtask

  task automatic test_done_overlap();
    req_q.push_back({1'b0, 18'h0_0200, 8'h00});
    strobe(1'b0, 1'b1, 1'b0, 18'h0_0200, 8'h00);
    exp_req = req_q.pop_front();
    chk_cnt++;
    if ({mif.mem_req, mif.mem_wr, mif.mem_addr, mif.mem_wdata} !== {1'b1, exp_req})
      $display("FAIL done_ovl_req: got req=%b fields=%h want 1 %h", mif.mem_req,
               {mif.mem_wr, mif.mem_addr, mif.mem_wdata}, exp_req);
    else pass_cnt++;
    mif.mem_rdata = 8'h3C;
    mif.mem_ack   = 1'b1;
    tick();
    mif.mem_ack = 1'b0;
    chk_cnt++;
    if ({busy, overrun, card_oe, card_dout} !== {3'b101, 8'h3C})
      $display("FAIL done_state: got busy=%b ovr=%b oe=%b dout=%h want 1 0 1 3c", busy, overrun, card_oe, card_dout);
    else pass_cnt++;
    strobe(1'b1, 1'b0, 1'b1, 18'h0_0300, 8'h44);
    chk_cnt++;
    if ({overrun, mif.mem_req, busy, mif.mem_addr} !== {3'b100, 18'h0_0200})
      $display("FAIL done_ovl: got ovr=%b req=%b busy=%b addr=%h want 1 0 0 00200", overrun, mif.mem_req, busy, mif.mem_addr);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_back_to_back();
    for (int t = 0; t < 24; t++) begin
      int kind = $urandom_range(0, 3);
      logic [ADDR_W-1:0] a = ADDR_W'($urandom);
      logic [DATA_W-1:0] d = DATA_W'($urandom);
      logic [DATA_W-1:0] rdat = DATA_W'($urandom);
      int dly = $urandom_range(0, 3);
      int n = 0;
      if (kind == 3) begin
        if ($urandom_range(0, 1) == 1) strobe(1'b1, 1'b1, 1'b0, a, d);
        else strobe(1'b0, 1'b0, 1'b1, a, d);
        chk_cnt++;
        if ({mif.mem_req, busy, card_oe} !== 3'b000)
          $display("FAIL b2b_unqual[%0d]: got req=%b busy=%b oe=%b want 0 0 0", t, mif.mem_req, busy, card_oe);
        else pass_cnt++;
        $display("txn %0d: unqualified strobe addr=%h", t, a);
        continue;
      end
      req_q.push_back({kind == 2, a, d});
      if (kind == 2) strobe(1'b1, 1'b0, 1'b1, a, d);
      else strobe(1'b0, 1'b1, 1'b0, a, d);
      while (!mif.mem_req && n < 4) begin
        tick();
        n++;
      end
      exp_req = req_q.pop_front();
      chk_cnt++;
      if ({mif.mem_req, mif.mem_wr, mif.mem_addr, mif.mem_wdata, n} !== {1'b1, exp_req, 32'd0})
        $display("FAIL b2b_req[%0d]: got req=%b fields=%h wait=%0d want 1 %h 0", t, mif.mem_req,
                 {mif.mem_wr, mif.mem_addr, mif.mem_wdata}, n, exp_req);
      else pass_cnt++;
      repeat (dly) tick();
      mif.mem_rdata = rdat;
      mif.mem_ack   = 1'b1;
      if (kind != 2) rd_q.push_back(rdat);
      tick();
      mif.mem_ack = 1'b0;
      chk_cnt++;
      if (kind != 2) begin
        exp_rd = rd_q.pop_front();
        if ({mif.mem_req, card_oe, card_dout} !== {2'b01, exp_rd})
          $display("FAIL b2b_rd[%0d]: got req=%b oe=%b dout=%h want 0 1 %h", t, mif.mem_req, card_oe, card_dout, exp_rd);
        else pass_cnt++;
      end else begin
        if ({mif.mem_req, card_oe} !== 2'b00)
          $display("FAIL b2b_wr[%0d]: got req=%b oe=%b want 0 0", t, mif.mem_req, card_oe);
        else pass_cnt++;
      end
      tick();
      chk_cnt++;
      if (busy !== 1'b0) $display("FAIL b2b_idle[%0d]: got busy=%b want 0", t, busy);
      else pass_cnt++;
      $display("txn %0d: %s addr=%h wdata=%h rdata=%h ack_delay=%0d", t,
               (kind == 2) ? "write" : "read ", a, d, rdat, dly);
    end
  endtask

`ifdef CARD_RAM_TIMEOUT_EN
  task automatic test_timeout();
    int n = 0;
    req_q.push_back({1'b0, 18'h0_0400, 8'h00});
    strobe(1'b0, 1'b1, 1'b0, 18'h0_0400, 8'h00);
    exp_req = req_q.pop_front();
    chk_cnt++;
    if ({mif.mem_req, mif.mem_wr, mif.mem_addr, mif.mem_wdata} !== {1'b1, exp_req})
      $display("FAIL tmo_req: got req=%b fields=%h want 1 %h", mif.mem_req,
               {mif.mem_wr, mif.mem_addr, mif.mem_wdata}, exp_req);
    else pass_cnt++;
    while (mif.mem_req && n < 100) begin
      tick();
      n++;
    end
    chk_cnt++;
    if (n !== 24) $display("FAIL tmo_len: got %0d REQ cycles want 24", n);
    else pass_cnt++;
    chk_cnt++;
    if ({card_oe, card_dout, tmo_err} !== {1'b1, 8'hFF, 1'b1})
      $display("FAIL tmo_result: got oe=%b dout=%h err=%b want 1 ff 1", card_oe, card_dout, tmo_err);
    else pass_cnt++;
    tick();
  endtask
`endif

  initial begin
    mif.mem_ack   = 1'b0;
    mif.mem_rdata = '0;
    test_reset();
    test_read_hit();
    test_write_protect();
    test_write();
    test_overlap();
    test_reset_mid();
    test_done_overlap();
    test_back_to_back();
`ifdef CARD_RAM_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end
endmodule
